// File: rtl/snes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snes_pkg
//  Purpose  : Shared types and constants for the SNES pad responder
//             (device-side end of the SNES controller serial protocol).
//  Contents : snes_resp_state_t - responder FSM states
//             SNES_NUM_BITS     - bits per frame
//             SNES_IDX_W        - width of the bit index (must hold 0..16)
//  Revision : 1.0 - initial release
// ============================================================================
package snes_pkg;

  localparam int SNES_NUM_BITS = 16;
  localparam int SNES_IDX_W    = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCHED = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } snes_resp_state_t;

endpackage
`default_nettype wire

// File: rtl/snes_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module   : snes_pin_sync
//  Purpose  : Brings one asynchronous protocol pin into the clk domain through
//             a 2-flop synchronizer, optionally debounces it, and reports the
//             current level plus single-cycle rise/fall strobes.
//  Macro    : SNES_RESP_GLITCH_FILTER_EN - when defined, the synchronized pin
//             only changes after FILT_CYCLES consecutive differing samples.
//  Ports    : clk       - system clock
//             rst_b     - synchronous active-low reset
//             pin_async - raw pin from the host
//             level     - synchronized (and filtered) pin level
//             rise      - high for one cycle after level goes 0->1
//             fall      - high for one cycle after level goes 1->0
//  Revision : 1.0 - initial release
// ============================================================================
module snes_pin_sync #(
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic pin_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic cur;

  // Reject out-of-range filter lengths at elaboration: the counter is 4 bits.
  if (FILT_CYCLES < 2 || FILT_CYCLES > 15) begin : g_filt_range_check
    $error("snes_pin_sync: FILT_CYCLES must be in 2..15");
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_async;
      sync2_q <= sync1_q;
    end
  end

`ifdef SNES_RESP_GLITCH_FILTER_EN
  logic       filt_q;
  logic       filt_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Count consecutive samples that disagree with the filtered value; the
  // FILT_CYCLES-th such sample flips it. Any agreeing sample restarts the run.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = 4'd0;
    if (sync2_q != filt_q) begin
      if (cnt_q == 4'(FILT_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      filt_q <= 1'b0;
      cnt_q  <= 4'd0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cur = filt_q;
`else
  assign cur = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= cur;
    end
  end

  // Both operands are flops, so the strobes are glitch-free and the FSM flop
  // that consumes them is the third register after the pin.
  assign level = cur;
  assign rise  = cur & ~prev_q;
  assign fall  = ~cur & prev_q;

endmodule
`default_nettype wire

// File: rtl/snes_pad_responder.sv
`default_nettype none
// ============================================================================
//  Module   : snes_pad_responder
//  Purpose  : Emulates a SNES game pad: captures `buttons` while the host
//             latch is high and shifts them out LSB first, active-low, one bit
//             per rising edge of the host data clock.
//  Macro    : SNES_RESP_GLITCH_FILTER_EN - adds a FILT_CYCLES glitch filter on
//             both protocol pins (passed through to snes_pin_sync).
//  Ports    : clk, rst_b   - system clock, synchronous active-low reset
//             buttons      - 1 = pressed, bit 0 shifted first
//             data_latch   - host latch (asynchronous)
//             data_clock   - host shift clock (asynchronous)
//             serial_data  - pad data line, 0 = pressed
//             busy         - frame in progress (LATCHED or SHIFT)
//             frame_done   - one-cycle pulse after the 16th bit
//             frame_abort  - one-cycle pulse when a latch interrupts SHIFT
//             bit_idx      - index of the bit being driven, 0..16
//  Revision : 1.0 - initial release
// ============================================================================
module snes_pad_responder
  import snes_pkg::*;
#(
  parameter int FILT_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [SNES_NUM_BITS-1:0] buttons,
  input  logic                     data_latch,
  input  logic                     data_clock,
  output logic                     serial_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_abort,
  output logic [SNES_IDX_W-1:0]    bit_idx
);

  logic latch_level;
  logic latch_rise;
  logic latch_fall;
  logic clk_level;
  logic clk_rise;
  logic clk_fall;

  snes_pin_sync #(
    .FILT_CYCLES (FILT_CYCLES)
  ) u_latch_sync (
    .clk       (clk),
    .rst_b     (rst_b),
    .pin_async (data_latch),
    .level     (latch_level),
    .rise      (latch_rise),
    .fall      (latch_fall)
  );

  snes_pin_sync #(
    .FILT_CYCLES (FILT_CYCLES)
  ) u_clock_sync (
    .clk       (clk),
    .rst_b     (rst_b),
    .pin_async (data_clock),
    .level     (clk_level),
    .rise      (clk_rise),
    .fall      (clk_fall)
  );

  // Only the latch level/fall and the clock rise drive the protocol.
  logic unused_pin_events;
  assign unused_pin_events = ^{latch_rise, clk_level, clk_fall};

  snes_resp_state_t         state_q,       state_d;
  logic [SNES_NUM_BITS-1:0] sr_q,          sr_d;
  logic [SNES_IDX_W-1:0]    bit_idx_q,     bit_idx_d;
  logic                     serial_data_q, serial_data_d;
  logic                     busy_q,        busy_d;
  logic                     frame_done_q,  frame_done_d;
  logic                     frame_abort_q, frame_abort_d;

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    bit_idx_d     = bit_idx_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;

    // The snapshot tracks `buttons` for as long as the latch is high, in any
    // state, so the frame reports the value seen on the latch's last high cycle.
    if (latch_level) begin
      sr_d = buttons;
    end

    unique case (state_q)
      IDLE: begin
        if (latch_level) begin
          state_d = LATCHED;
        end
      end
      LATCHED: begin
        bit_idx_d = '0;
        if (latch_fall) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Latch wins over a clock edge arriving in the same cycle.
        if (latch_level) begin
          state_d       = LATCHED;
          bit_idx_d     = '0;
          frame_abort_d = 1'b1;
        end else if (clk_rise) begin
          sr_d      = {1'b0, sr_q[SNES_NUM_BITS-1:1]};
          bit_idx_d = bit_idx_q + SNES_IDX_W'(1);
          if (bit_idx_q == SNES_IDX_W'(SNES_NUM_BITS - 1)) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end
        end
      end
      DONE: begin
        // Further clock edges are ignored; bit_idx parks at 16.
        if (latch_level) begin
          state_d   = LATCHED;
          bit_idx_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next-state values so they change on the
    // same edge as the state they describe.
    unique case (state_d)
      IDLE:    serial_data_d = 1'b1;
      DONE:    serial_data_d = 1'b0;
      default: serial_data_d = ~sr_d[0];
    endcase
    busy_d = (state_d == LATCHED) || (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      bit_idx_q     <= '0;
      serial_data_q <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      bit_idx_q     <= bit_idx_d;
      serial_data_q <= serial_data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign serial_data = serial_data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign bit_idx     = bit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_pad_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snes_pad_responder
//  Purpose  : Self-checking bench for snes_pad_responder. A frame-level model
//             (pins delayed by the synchronizer, then the protocol rules) is
//             compared against the DUT every cycle; directed host transactions
//             add literal expectations for captured words and latencies.
//  Macro    : SNES_RESP_GLITCH_FILTER_EN - enables the filter checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snes_pad_responder;
  import snes_pkg::*;

  localparam int FILT = 4;
  localparam int HALF = 10;
`ifdef SNES_RESP_GLITCH_FILTER_EN
  localparam int LAT  = 3 + FILT;
`else
  localparam int LAT  = 3;
`endif

  logic                  clk        = 1'b0;
  logic                  rst_b      = 1'b0;
  logic [15:0]           buttons    = 16'h0000;
  logic                  data_latch = 1'b0;
  logic                  data_clock = 1'b0;
  logic                  serial_data;
  logic                  busy;
  logic                  frame_done;
  logic                  frame_abort;
  logic [SNES_IDX_W-1:0] bit_idx;

  int n_chk     = 0;
  int n_fail    = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;
  bit chk_en    = 1'b0;

  always #5 clk = ~clk;

  snes_pad_responder #(
    .FILT_CYCLES (FILT)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .buttons     (buttons),
    .data_latch  (data_latch),
    .data_clock  (data_clock),
    .serial_data (serial_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .bit_idx     (bit_idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Index 0 = latch pin, 1 = clock pin. hN = pin as sampled N edges ago.
  logic        h1[2], h2[2], h3[2];
  logic        f_lvl[2], f_prev[2];
  int          f_run[2];
  int          m_phase;   // 0 idle, 1 latched, 2 shifting, 3 done
  int          m_cnt;     // bits already shifted past
  logic [15:0] m_word;    // frame snapshot, never shifted
  logic        m_done, m_abort;

  always @(posedge clk) begin
    logic lvl[2];
    logic prv[2];
    logic pin_now[2];
    pin_now[0] = data_latch;
    pin_now[1] = data_clock;
    if (!rst_b) begin
      for (int k = 0; k < 2; k++) begin
        h1[k] = 1'b0; h2[k] = 1'b0; h3[k] = 1'b0;
        f_lvl[k] = 1'b0; f_prev[k] = 1'b0; f_run[k] = 0;
      end
      m_phase = 0; m_cnt = 0; m_word = 16'h0000; m_done = 1'b0; m_abort = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
`ifdef SNES_RESP_GLITCH_FILTER_EN
        lvl[k]    = f_lvl[k];
        prv[k]    = f_prev[k];
        f_prev[k] = f_lvl[k];
        if (h2[k] != f_lvl[k]) begin
          f_run[k]++;
          if (f_run[k] == FILT) begin
            f_lvl[k] = h2[k];
            f_run[k] = 0;
          end
        end else begin
          f_run[k] = 0;
        end
`else
        lvl[k] = h2[k];
        prv[k] = h3[k];
`endif
        h3[k] = h2[k];
        h2[k] = h1[k];
        h1[k] = pin_now[k];
      end
      m_done  = 1'b0;
      m_abort = 1'b0;
      if (lvl[0]) begin
        m_abort = (m_phase == 2);
        m_phase = 1;
        m_word  = buttons;
        m_cnt   = 0;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && lvl[1] && !prv[1]) begin
        m_cnt++;
        if (m_cnt == 16) begin
          m_phase = 3;
          m_done  = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    logic exp_serial;
    if (m_phase == 0)      exp_serial = 1'b1;
    else if (m_phase == 3) exp_serial = 1'b0;
    else                   exp_serial = ~m_word[m_cnt];
    if (chk_en) begin
      chk("serial_data", 32'(serial_data), 32'(exp_serial));
      chk("busy",        32'(busy),        32'(m_phase == 1 || m_phase == 2));
      chk("frame_done",  32'(frame_done),  32'(m_done));
      chk("frame_abort", 32'(frame_abort), 32'(m_abort));
      chk("bit_idx",     32'(bit_idx),     32'(m_cnt));
      if (frame_done === 1'b1)  done_cnt++;
      if (frame_abort === 1'b1) abort_cnt++;
    end
  end

  // ---------------------------------------------------------------- host
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latch_pulse();
    data_latch = 1'b1;
    tick(HALF);
    data_latch = 1'b0;
    tick(HALF);
  endtask

  // Reads the driven bit just before each rising edge, like the host does.
  task automatic clocks(input int n, output logic [31:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      cap[i]     = serial_data;
      data_clock = 1'b1;
      tick(HALF);
      data_clock = 1'b0;
      tick(HALF);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    logic [31:0] cap, cap2;
    int d0;

    // Reset values
    tick(3);
    chk_en = 1'b1;
    chk("rst_serial", 32'(serial_data), 32'd1);
    chk("rst_busy",   32'(busy),        32'd0);
    chk("rst_idx",    32'(bit_idx),     32'd0);
    chk("rst_done",   32'(frame_done),  32'd0);
    rst_b = 1'b1;
    tick(3);

    // Frame 1: single button, latch-to-bit0 latency
    buttons = 16'h0001;
    d0 = done_cnt;
    data_latch = 1'b1;
    tick(LAT - 1);
    chk("latch_lat_early", 32'(busy), 32'd0);
    tick(1);
    chk("latch_lat_busy", 32'(busy), 32'd1);
    chk("latch_lat_bit0", 32'(serial_data), 32'd0);
    tick(HALF - LAT);
    data_latch = 1'b0;
    tick(HALF);
    clocks(16, cap);
    chk("f1_word",  cap, 32'h0000_FFFE);
    chk("f1_after", 32'(serial_data), 32'd0);
    chk("f1_idx",   32'(bit_idx), 32'd16);
    chk("f1_done",  32'(done_cnt - d0), 32'd1);

    // Frame 2: buttons change mid-frame without affecting it
    buttons = 16'hA5C3;
    latch_pulse();
    clocks(8, cap);
    buttons = 16'hFFFF;
    clocks(8, cap2);
    chk("f2_word", {16'h0, cap2[7:0], cap[7:0]}, 32'h0000_5A3C);

    // Abort after 7 clocks, then a full frame with new buttons
    d0 = abort_cnt;
    latch_pulse();
    clocks(7, cap);
    chk("abort_pre_idx", 32'(bit_idx), 32'd7);
    data_latch = 1'b1;
    tick(LAT);
    chk("abort_pulse", 32'(frame_abort), 32'd1);
    chk("abort_idx",   32'(bit_idx), 32'd0);
    tick(1);
    chk("abort_width", 32'(frame_abort), 32'd0);
    buttons = 16'h3C96;
    tick(HALF - LAT - 1);
    data_latch = 1'b0;
    tick(HALF);
    clocks(16, cap);
    chk("abort_count", 32'(abort_cnt - d0), 32'd1);
    chk("f3_word", cap, 32'h0000_C369);

    // 20 clocks: bits 16..19 read 0, only one frame_done
    buttons = 16'h8001;
    d0 = done_cnt;
    latch_pulse();
    clocks(20, cap);
    chk("f4_word",  {16'h0, cap[15:0]}, 32'h0000_7FFE);
    chk("f4_extra", 32'(cap[19:16]), 32'd0);
    chk("f4_done",  32'(done_cnt - d0), 32'd1);
    chk("f4_idx",   32'(bit_idx), 32'd16);

    // Clock edges while latch high are ignored
    data_latch = 1'b1;
    tick(HALF);
    for (int i = 0; i < 2; i++) begin
      data_clock = 1'b1;
      tick(HALF);
      data_clock = 1'b0;
      tick(HALF);
    end
    chk("latch_hi_idx",  32'(bit_idx), 32'd0);
    chk("latch_hi_busy", 32'(busy), 32'd1);
    data_latch = 1'b0;
    tick(HALF);
    chk("latch_lo_idx",  32'(bit_idx), 32'd0);

`ifdef SNES_RESP_GLITCH_FILTER_EN
    // Short glitch rejected; 5-cycle pulse accepted with LAT latency
    data_clock = 1'b1;
    tick(3);
    data_clock = 1'b0;
    tick(2 * HALF);
    chk("glitch_idx", 32'(bit_idx), 32'd0);
    data_clock = 1'b1;
    tick(5);
    data_clock = 1'b0;
    tick(1);
    chk("pulse_early_idx", 32'(bit_idx), 32'd0);
    tick(1);
    chk("pulse_lat_idx", 32'(bit_idx), 32'd1);
    tick(2 * HALF);
`endif

    // Reset in the middle of SHIFT
    buttons = 16'h1234;
    latch_pulse();
    clocks(9, cap);
    chk("pre_rst_idx", 32'(bit_idx), 32'd9);
    rst_b = 1'b0;
    tick(1);
    chk("mid_rst_serial", 32'(serial_data), 32'd1);
    chk("mid_rst_busy",   32'(busy), 32'd0);
    chk("mid_rst_idx",    32'(bit_idx), 32'd0);
    tick(2);
    rst_b = 1'b1;
    tick(4);
    chk("post_rst_busy", 32'(busy), 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snes_pad_responder.md
# snes_pad_responder

Device-side end of the SNES controller serial protocol: samples `data_latch` and `data_clock` from a host and shifts out a 16-bit button word on `serial_data`, bit-for-bit as a real SNES pad does. It is the counterpart of the `controller` host interface. It serves as a loopback target on the JA header, letting the whole `buttons` → `controller` path and the LED debug mux be exercised without a physical pad. It runs in the GCLK domain, with all protocol inputs treated as asynchronous.

## Interface
- `FILT_CYCLES`, default 4: consecutive equal samples required before a filtered pin changes value. Used only when the glitch filter is compiled in; range 2–15.
- `clk`  input  1: system clock, the GCLK domain.
- `rst_b`  input  1: reset, synchronous and active-low.
- `buttons`  input  16: button state to report, 1 = pressed. Bit 0 is shifted first.
- `data_latch`  input  1: host latch, asynchronous, active-high.
- `data_clock`  input  1: host shift clock, asynchronous. Rising edge advances one bit.
- `serial_data`  output  1: pad data line, active-low (0 = pressed). Reset value 1.
- `busy`  output  1: high in LATCHED or SHIFT. Reset value 0.
- `frame_done`  output  1: one-cycle pulse when the 16th bit has been shifted past. Reset value 0.
- `frame_abort`  output  1: one-cycle pulse when a latch arrives during SHIFT. Reset value 0.
- `bit_idx`  output  5: index of the bit currently driven, 0–16. Reset value 0.

## Operation
- Both pins pass through a 2-flop synchronizer. The edge detector then compares the registered current value with the registered previous value.
- The 16-bit shift register `sr` is loaded with `buttons` on every cycle while the synchronized latch is high. The snapshot is the value present on the cycle the latch falls.
- `serial_data` = ~`sr[0]` in LATCHED and SHIFT, 1 in IDLE, and 0 in DONE. A DONE line of 0 matches genuine pad behaviour after 16 bits.
- States and transitions:
  - IDLE → LATCHED on latch high.
  - LATCHED → SHIFT on latch fall. `bit_idx` = 0.
  - SHIFT, on each `data_clock` rising edge: `sr` shifts right with 0 fill and `bit_idx` increments. When `bit_idx` reaches 16, `frame_done` pulses and the FSM enters DONE.
  - SHIFT → LATCHED on latch high, with a `frame_abort` pulse.
  - DONE → LATCHED on latch high. In DONE, clock edges are ignored and `bit_idx` holds at 16.
- A clock edge while the latch is high is ignored. The latch has priority over a clock edge seen in the same cycle.
- If `buttons` changes after the latch falls, the current frame is unaffected.
- A reset during any state returns the block to IDLE with all outputs at their reset values. `sr` is cleared to 0.

## Timing
- Latency from pin edge to response is exactly 3 `clk` cycles: 2 synchronizer stages plus the edge register. This covers both `data_clock`↑ to the new `serial_data` and latch↓ to SHIFT.
- Bit 0 is valid on `serial_data` 3 cycles after latch↑, and it remains valid through the latch fall.
- Pin pulses must be at least 2 `clk` cycles wide to be seen. The host's 6 µs half-periods at 100 MHz (600 cycles) give ample margin.
- `frame_done` and `frame_abort` are registered and each lasts exactly one cycle. They are never asserted in the same cycle.

## Configuration
- `SNES_RESP_GLITCH_FILTER_EN` defined:
  - After each synchronizer, a 4-bit counter per pin updates the filtered value only after `FILT_CYCLES` consecutive samples differing from it.
  - Latency becomes 3 + `FILT_CYCLES` cycles.
  - Pulses shorter than `FILT_CYCLES` cycles are rejected.
- Not defined: there is no filter or counter logic, the latency is 3 cycles, and `FILT_CYCLES` is ignored.

## Structure
- Package `snes_pkg` holds:
  - the state enum `snes_resp_state_t` (IDLE, LATCHED, SHIFT, DONE);
  - `SNES_NUM_BITS` = 16;
  - `SNES_IDX_W` = 5.
- Sub-module `snes_pin_sync`: synchronizer, optional filter, and registered rise/fall outputs. It is instantiated once per pin.
- The top level contains the FSM, shift register and bit counter.

## Test plan
- `buttons`=16'h0001, one latch pulse, 16 clocks → `serial_data` is 0 for bit 0 and 1 for bits 1–15, 0 after the 16th clock. `frame_done` pulses once, `bit_idx`=16.
- `buttons`=16'hA5C3 → captured sequence (inverted, LSB first) equals ~16'hA5C3. `buttons` is changed to 16'hFFFF mid-frame with no effect on the captured sequence.
- Latch re-asserted after 7 clocks → `frame_abort` pulses. A full new frame then reports the current `buttons`. `bit_idx` resets to 0.
- 20 clocks after the latch → bits 16–19 read 0, with no second `frame_done`. Clock edges while the latch is high → `bit_idx` stays at 0.
- `rst_b`=0 mid-SHIFT (bit 9) → next cycle IDLE, `serial_data`=1, `busy`=0, `bit_idx`=0.
- With `SNES_RESP_GLITCH_FILTER_EN`, `FILT_CYCLES`=4: a 3-cycle `data_clock` glitch leaves `bit_idx` unchanged. A 5-cycle pulse advances it by 1, with a 7-cycle response latency.
